// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB-to-I2C register bank.
// Holds the register offsets, the STATUS / INT_STAT bit positions and the
// APB slave phase-tracking state type.
package apb_i2c_pkg;

  // Register byte offsets
  localparam int unsigned OFF_TXDATA  = 32'h00;
  localparam int unsigned OFF_RXDATA  = 32'h04;
  localparam int unsigned OFF_CONFIG  = 32'h08;
  localparam int unsigned OFF_TIMEOUT = 32'h0C;
  localparam int unsigned OFF_STATUS  = 32'h10;
  localparam int unsigned OFF_INT_EN  = 32'h14;
  localparam int unsigned OFF_INT_ST  = 32'h18;

  // STATUS bit positions
  localparam int STS_TX_FULL  = 0;
  localparam int STS_TX_EMPTY = 1;
  localparam int STS_RX_EMPTY = 2;
  localparam int STS_ERROR    = 3;

  // INT_STAT / INT_EN bit positions
  localparam int INT_TX_EMPTY = 0;  // TX FIFO drained
  localparam int INT_RX_DATA  = 1;  // RX FIFO received data
  localparam int INT_ERROR    = 2;  // I2C core error raised
  localparam int INT_SLVERR   = 3;  // an APB access completed with PSLVERR
  localparam int NUM_INT      = 4;

  // ST_SETUP: a setup phase was seen on the previous cycle, so this is the
  // first access cycle. ST_ACCESS: subsequent (wait) access cycles.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_i2c_irq.sv
// Interrupt block: edge detectors on the FIFO/core flags, sticky INT_STAT
// with write-1-to-clear (a set in the same cycle wins), registered IRQ.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   tx_empty, rx_empty,     raw flag levels from FIFOs / I2C core
//   error
//   slverr_evt              one-cycle pulse on any PSLVERR completion
//   clr                     W1C mask (already qualified by a successful write)
//   int_en                  interrupt enable mask
//   int_stat                pending interrupt bits
//   irq                     |(int_stat & int_en), registered
module apb_i2c_irq
  import apb_i2c_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_empty,
  input  logic               rx_empty,
  input  logic               error,
  input  logic               slverr_evt,
  input  logic [NUM_INT-1:0] clr,
  input  logic [NUM_INT-1:0] int_en,
  output logic [NUM_INT-1:0] int_stat,
  output logic               irq
);

  logic               tx_empty_q;
  logic               rx_empty_q;
  logic               error_q;
  logic [NUM_INT-1:0] set_s;
  logic [NUM_INT-1:0] int_stat_d;
  logic [NUM_INT-1:0] int_stat_q;
  logic               irq_d;
  logic               irq_q;

  // Edge events and next INT_STAT/IRQ; set is OR-ed after clear so it wins
  always_comb begin
    set_s               = 4'b0000;
    set_s[INT_TX_EMPTY] = tx_empty & ~tx_empty_q;
    set_s[INT_RX_DATA]  = ~rx_empty & rx_empty_q;
    set_s[INT_ERROR]    = error & ~error_q;
    set_s[INT_SLVERR]   = slverr_evt;
    int_stat_d          = (int_stat_q & ~clr) | set_s;
    irq_d               = |(int_stat_q & int_en);
  end

  // Previous flag levels, sticky status and IRQ line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_empty_q <= 1'b1;
      rx_empty_q <= 1'b1;
      error_q    <= 1'b0;
      int_stat_q <= 4'b0000;
      irq_q      <= 1'b0;
    end else begin
      tx_empty_q <= tx_empty;
      rx_empty_q <= rx_empty;
      error_q    <= error;
      int_stat_q <= int_stat_d;
      irq_q      <= irq_d;
    end
  end

  assign int_stat = int_stat_q;
  assign irq      = irq_q;

endmodule

// File: rtl/apb_i2c_regbank.sv
// APB3 slave register bank in front of the I2C core and its TX/RX FIFOs.
// Decodes TXDATA/RXDATA/CONFIG/TIMEOUT/STATUS/INT_EN/INT_STAT, inserts wait
// states while the addressed FIFO is blocked (bounded by STALL_MAX), and
// flags bad accesses with a zero-wait PSLVERR.
// Ports:
//   PCLK, PRESETn                     clock, async active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request
//   PRDATA/PREADY/PSLVERR             APB response
//   WR_ENA, WRITE_DATA_ON_TX          TX FIFO push
//   TX_FULL, TX_EMPTY                 TX FIFO flags
//   RD_ENA, READ_DATA_ON_RX, RX_EMPTY RX FIFO pop / head / flag
//   ERROR                             I2C core error level
//   I2C_CONFIG, I2C_TIMEOUT           configuration registers
//   IRQ                               interrupt request
module apb_i2c_regbank
  import apb_i2c_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int CFG_W     = 14,
  parameter int TMO_W     = 14,
  parameter int STALL_MAX = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              WR_ENA,
  output logic [DATA_W-1:0] WRITE_DATA_ON_TX,
  input  logic              TX_FULL,
  input  logic              TX_EMPTY,
  output logic              RD_ENA,
  input  logic [DATA_W-1:0] READ_DATA_ON_RX,
  input  logic              RX_EMPTY,
  input  logic              ERROR,
  output logic [CFG_W-1:0]  I2C_CONFIG,
  output logic [TMO_W-1:0]  I2C_TIMEOUT,
  output logic              IRQ
);

  localparam int CNT_W = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
  localparam logic [CNT_W-1:0]  STALL_LIM = CNT_W'(STALL_MAX);
  localparam logic [ADDR_W-1:0] A_TXDATA  = ADDR_W'(OFF_TXDATA);
  localparam logic [ADDR_W-1:0] A_RXDATA  = ADDR_W'(OFF_RXDATA);
  localparam logic [ADDR_W-1:0] A_CONFIG  = ADDR_W'(OFF_CONFIG);
  localparam logic [ADDR_W-1:0] A_TIMEOUT = ADDR_W'(OFF_TIMEOUT);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(OFF_STATUS);
  localparam logic [ADDR_W-1:0] A_INT_EN  = ADDR_W'(OFF_INT_EN);
  localparam logic [ADDR_W-1:0] A_INT_ST  = ADDR_W'(OFF_INT_ST);

  apb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [NUM_INT-1:0] ien_q, ien_d;

  logic sel_tx_s, sel_rx_s, sel_cfg_s, sel_tmo_s, sel_sts_s, sel_ien_s, sel_ist_s;
  logic hit_s, bad_s, blocked_s, timeout_s, active_s, pready_s, pslverr_s, ok_s, wr_ok_s;
  logic [3:0]         sts_s;
  logic [NUM_INT-1:0] w1c_s, int_stat_s;
  logic [DATA_W-1:0]  rdata_s;

  // Address decode; anything not listed (including unaligned) is unmapped
  always_comb begin
    sel_tx_s  = 1'b0;
    sel_rx_s  = 1'b0;
    sel_cfg_s = 1'b0;
    sel_tmo_s = 1'b0;
    sel_sts_s = 1'b0;
    sel_ien_s = 1'b0;
    sel_ist_s = 1'b0;
    case (PADDR)
      A_TXDATA:  sel_tx_s  = 1'b1;
      A_RXDATA:  sel_rx_s  = 1'b1;
      A_CONFIG:  sel_cfg_s = 1'b1;
      A_TIMEOUT: sel_tmo_s = 1'b1;
      A_STATUS:  sel_sts_s = 1'b1;
      A_INT_EN:  sel_ien_s = 1'b1;
      A_INT_ST:  sel_ist_s = 1'b1;
      default:   sel_tx_s  = 1'b0;
    endcase
  end

  assign hit_s = sel_tx_s | sel_rx_s | sel_cfg_s | sel_tmo_s | sel_sts_s | sel_ien_s | sel_ist_s;
  assign bad_s = ~hit_s | (PWRITE & (sel_rx_s | sel_sts_s)) | (~PWRITE & sel_tx_s);
  assign blocked_s = ~bad_s & ((PWRITE & sel_tx_s & TX_FULL) | (~PWRITE & sel_rx_s & RX_EMPTY));
  // Counter equals the number of wait cycles already spent in this transfer
  assign timeout_s = blocked_s & (stall_q == STALL_LIM);

  // Access phase: a setup was tracked and the bus is still presenting it
  assign active_s  = (state_q != ST_IDLE) & PSEL & PENABLE;
  assign pready_s  = active_s & (~blocked_s | timeout_s);
  assign pslverr_s = active_s & (bad_s | timeout_s);
  assign ok_s      = active_s & ~bad_s & ~blocked_s;
  assign wr_ok_s   = ok_s & PWRITE;

  assign cfg_d = (wr_ok_s & sel_cfg_s) ? PWDATA[CFG_W-1:0] : cfg_q;
  assign tmo_d = (wr_ok_s & sel_tmo_s) ? PWDATA[TMO_W-1:0] : tmo_q;
  assign ien_d = (wr_ok_s & sel_ien_s) ? PWDATA[NUM_INT-1:0] : ien_q;
  assign w1c_s = (wr_ok_s & sel_ist_s) ? PWDATA[NUM_INT-1:0] : 4'b0000;

  // STATUS word assembled from the live flag levels
  always_comb begin
    sts_s               = 4'b0000;
    sts_s[STS_TX_FULL]  = TX_FULL;
    sts_s[STS_TX_EMPTY] = TX_EMPTY;
    sts_s[STS_RX_EMPTY] = RX_EMPTY;
    sts_s[STS_ERROR]    = ERROR;
  end

  // Read mux; RXDATA returns the fall-through FIFO head
  always_comb begin
    if (sel_rx_s)       rdata_s = READ_DATA_ON_RX;
    else if (sel_cfg_s) rdata_s = DATA_W'(cfg_q);
    else if (sel_tmo_s) rdata_s = DATA_W'(tmo_q);
    else if (sel_sts_s) rdata_s = DATA_W'(sts_s);
    else if (sel_ien_s) rdata_s = DATA_W'(ien_q);
    else if (sel_ist_s) rdata_s = DATA_W'(int_stat_s);
    else                rdata_s = '0;
  end

  // Next phase and stall count
  always_comb begin
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) state_d = ST_SETUP;
        else                  state_d = ST_IDLE;
      end
      ST_SETUP, ST_ACCESS: begin
        // A dropped PSEL/PENABLE abandons the transfer like a completion
        if (pready_s || !active_s) state_d = (PSEL && !PENABLE) ? ST_SETUP : ST_IDLE;
        else                       state_d = ST_ACCESS;
      end
      default: state_d = ST_IDLE;
    endcase
    if (pready_s || !active_s) stall_d = '0;
    else if (blocked_s)        stall_d = stall_q + CNT_W'(1);
    else                       stall_d = stall_q;
  end

  // Phase, stall counter and configuration registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      stall_q <= '0;
      cfg_q   <= '0;
      tmo_q   <= '0;
      ien_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      cfg_q   <= cfg_d;
      tmo_q   <= tmo_d;
      ien_q   <= ien_d;
    end
  end

  apb_i2c_irq u_irq (
    .clk        (PCLK),
    .rst_n      (PRESETn),
    .tx_empty   (TX_EMPTY),
    .rx_empty   (RX_EMPTY),
    .error      (ERROR),
    .slverr_evt (pready_s & pslverr_s),
    .clr        (w1c_s),
    .int_en     (ien_q),
    .int_stat   (int_stat_s),
    .irq        (IRQ)
  );

  assign PREADY           = pready_s;
  assign PSLVERR          = pslverr_s;
  assign PRDATA           = active_s ? rdata_s : '0;
  assign WR_ENA           = ok_s & PWRITE & sel_tx_s;
  assign RD_ENA           = ok_s & ~PWRITE & sel_rx_s;
  assign WRITE_DATA_ON_TX = PWDATA;
  assign I2C_CONFIG       = cfg_q;
  assign I2C_TIMEOUT      = tmo_q;

endmodule

// File: tb/tb_apb_i2c_regbank.sv
// Self-checking bench for apb_i2c_regbank: directed scenarios followed by
// randomized transfers, all checked against a register-level model.
module tb_apb_i2c_regbank;

  localparam int STALL_MAX = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]  PADDR = 8'h00;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, WR_ENA, RD_ENA, IRQ;
  logic [31:0] WRITE_DATA_ON_TX;
  logic        TX_FULL = 1'b0, TX_EMPTY = 1'b1, RX_EMPTY = 1'b1, ERROR = 1'b0;
  logic [31:0] READ_DATA_ON_RX = 32'h0;
  logic [13:0] I2C_CONFIG, I2C_TIMEOUT;

  apb_i2c_regbank #(.DATA_W(32), .ADDR_W(8), .CFG_W(14), .TMO_W(14), .STALL_MAX(STALL_MAX)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .WR_ENA(WR_ENA), .WRITE_DATA_ON_TX(WRITE_DATA_ON_TX), .TX_FULL(TX_FULL), .TX_EMPTY(TX_EMPTY),
    .RD_ENA(RD_ENA), .READ_DATA_ON_RX(READ_DATA_ON_RX), .RX_EMPTY(RX_EMPTY), .ERROR(ERROR),
    .I2C_CONFIG(I2C_CONFIG), .I2C_TIMEOUT(I2C_TIMEOUT), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: register contents and flag levels last seen by the DUT
  logic [13:0] m_cfg, m_tmo;
  logic [3:0]  m_ien, m_istat;
  logic        m_txe, m_rxe, m_err;

  logic [7:0] addrs [11] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                             8'h1C, 8'h02, 8'h20, 8'hFC};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive flag levels and record the interrupt events they imply
  task automatic drive_flags(input logic tf, input logic te, input logic re, input logic er);
    TX_FULL = tf; TX_EMPTY = te; RX_EMPTY = re; ERROR = er;
    if (te && !m_txe) m_istat[0] = 1'b1;
    if (!re && m_rxe) m_istat[1] = 1'b1;
    if (er && !m_err) m_istat[2] = 1'b1;
    m_txe = te; m_rxe = re; m_err = er;
  endtask

  task automatic model_reset();
    m_cfg = '0; m_tmo = '0; m_ien = '0; m_istat = '0;
    m_txe = 1'b1; m_rxe = 1'b1; m_err = 1'b0;
    drive_flags(TX_FULL, TX_EMPTY, RX_EMPTY, ERROR);
  endtask

  // One APB transfer; 'rel' = wait-cycle index at which the blocking flag drops (-1: never)
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd, input int rel,
                     output logic [31:0] rd, output logic err, output int waits,
                     output int wrp, output int rdp, output logic [31:0] pushed);
    logic done;
    done = 1'b0; rd = '0; err = 1'b0; waits = 0; wrp = 0; rdp = 0; pushed = '0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int c = 0; c < 64 && !done; c++) begin
      if (waits == rel) begin
        if (wr) drive_flags(1'b0, TX_EMPTY, RX_EMPTY, ERROR);
        else    drive_flags(TX_FULL, TX_EMPTY, 1'b0, ERROR);
      end
      @(negedge PCLK);
      if (WR_ENA) begin wrp++; pushed = WRITE_DATA_ON_TX; end
      if (RD_ENA) rdp++;
      if (PREADY) begin done = 1'b1; rd = PRDATA; err = PSLVERR; end
      else waits++;
      @(posedge PCLK); #1;
    end
    chk("apb_completion_bound", 32'(done), 32'd1);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Transfer plus expectation derived from the register map rules
  task automatic do_xfer(input string tag, input logic wr, input logic [7:0] addr,
                         input logic [31:0] wd, input int rel);
    logic mapped, bad, blk, e_err;
    int e_waits, waits, wrp, rdp;
    logic [31:0] e_rd, rd, pushed;
    logic err;
    mapped = (addr inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18});
    bad = !mapped || (wr && (addr == 8'h04 || addr == 8'h10)) || (!wr && addr == 8'h00);
    blk = !bad && ((wr && addr == 8'h00 && TX_FULL) || (!wr && addr == 8'h04 && RX_EMPTY));
    e_err = bad || (blk && !(rel >= 0 && rel <= STALL_MAX));
    e_waits = blk ? (e_err ? STALL_MAX : rel) : 0;
    case (addr)
      8'h04:   e_rd = READ_DATA_ON_RX;
      8'h08:   e_rd = 32'(m_cfg);
      8'h0C:   e_rd = 32'(m_tmo);
      8'h10:   e_rd = {28'h0, ERROR, RX_EMPTY, TX_EMPTY, TX_FULL};
      8'h14:   e_rd = 32'(m_ien);
      8'h18:   e_rd = 32'(m_istat);
      default: e_rd = 32'h0;
    endcase
    apb(wr, addr, wd, blk ? rel : -1, rd, err, waits, wrp, rdp, pushed);
    chk({tag, "_pslverr"}, 32'(err), 32'(e_err));
    chk({tag, "_waits"}, 32'(waits), 32'(e_waits));
    chk({tag, "_wr_ena"}, 32'(wrp), (!e_err && wr && addr == 8'h00) ? 32'd1 : 32'd0);
    chk({tag, "_rd_ena"}, 32'(rdp), (!e_err && !wr && addr == 8'h04) ? 32'd1 : 32'd0);
    if (!e_err && wr && addr == 8'h00) chk({tag, "_push_data"}, pushed, wd);
    if (!e_err && !wr) chk({tag, "_prdata"}, rd, e_rd);
    if (e_err) m_istat[3] = 1'b1;
    else if (wr) begin
      case (addr)
        8'h08:   m_cfg = wd[13:0];
        8'h0C:   m_tmo = wd[13:0];
        8'h14:   m_ien = wd[3:0];
        8'h18:   m_istat = m_istat & ~wd[3:0];
        default: ;
      endcase
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge PCLK);
    #1;
    chk("reset_pready", 32'(PREADY), 32'd0);
    chk("reset_irq", 32'(IRQ), 32'd0);
    PRESETn = 1'b1;
    model_reset();

    // Reset values read back with zero waits, back-to-back
    do_xfer("rst_config", 1'b0, 8'h08, 32'h0, -1);
    do_xfer("rst_timeout", 1'b0, 8'h0C, 32'h0, -1);
    do_xfer("rst_int_stat", 1'b0, 8'h18, 32'h0, -1);

    // Width truncation of CONFIG / TIMEOUT
    do_xfer("wr_config", 1'b1, 8'h08, 32'h0000_3FFF, -1);
    do_xfer("wr_timeout", 1'b1, 8'h0C, 32'hFFFF_FFFF, -1);
    do_xfer("rd_config", 1'b0, 8'h08, 32'h0, -1);
    do_xfer("rd_timeout", 1'b0, 8'h0C, 32'h0, -1);
    chk("i2c_config_pin", 32'(I2C_CONFIG), 32'h3FFF);
    chk("i2c_timeout_pin", 32'(I2C_TIMEOUT), 32'h3FFF);

    // TX write blocked for 3 cycles
    drive_flags(1'b1, 1'b0, 1'b1, 1'b0);
    do_xfer("tx_blocked3", 1'b1, 8'h00, 32'hA5A5_0001, 3);

    // RX read never unblocked: stall timeout
    do_xfer("rx_timeout", 1'b0, 8'h04, 32'h0, -1);
    do_xfer("int_stat_slverr", 1'b0, 8'h18, 32'h0, -1);

    // ERROR interrupt path and IRQ latency
    do_xfer("clr_all", 1'b1, 8'h18, 32'hF, -1);
    do_xfer("int_en4", 1'b1, 8'h14, 32'h4, -1);
    drive_flags(TX_FULL, TX_EMPTY, RX_EMPTY, 1'b1);
    @(negedge PCLK); chk("irq_before_edge", 32'(IRQ), 32'd0);
    @(negedge PCLK); chk("irq_one_cycle", 32'(IRQ), 32'd0);
    @(negedge PCLK); chk("irq_two_cycles", 32'(IRQ), 32'd1);
    @(posedge PCLK); #1;
    drive_flags(TX_FULL, TX_EMPTY, RX_EMPTY, 1'b0);
    do_xfer("int_stat_err", 1'b0, 8'h18, 32'h0, -1);
    chk("int_stat_is_4", 32'(m_istat), 32'h4);
    do_xfer("w1c_err", 1'b1, 8'h18, 32'h4, -1);
    repeat (2) @(posedge PCLK);
    #1;
    chk("irq_cleared", 32'(IRQ), 32'd0);

    // Clear coincident with a new ERROR rising edge: set wins
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h18; PWDATA = 32'h4;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    m_istat = m_istat & ~4'h4;
    drive_flags(TX_FULL, TX_EMPTY, RX_EMPTY, 1'b1);
    @(negedge PCLK); chk("coinc_pready", 32'(PREADY), 32'd1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    drive_flags(TX_FULL, TX_EMPTY, RX_EMPTY, 1'b0);
    do_xfer("coinc_int_stat", 1'b0, 8'h18, 32'h0, -1);
    chk("coinc_bit2", 32'(m_istat[2]), 32'd1);
    @(posedge PCLK); #1;
    chk("coinc_irq", 32'(IRQ), 32'd1);

    // Bad accesses: zero-wait error, no side effects
    do_xfer("wr_status", 1'b1, 8'h10, 32'hFFFF_FFFF, -1);
    do_xfer("rd_txdata", 1'b0, 8'h00, 32'h0, -1);
    do_xfer("rd_1c", 1'b0, 8'h1C, 32'h0, -1);
    do_xfer("wr_1c", 1'b1, 8'h1C, 32'h1234_5678, -1);
    do_xfer("wr_unaligned", 1'b1, 8'h09, 32'h0000_0055, -1);
    do_xfer("config_kept", 1'b0, 8'h08, 32'h0, -1);

    // Randomized transfers
    for (int i = 0; i < 60; i++) begin
      int k, rel;
      logic w;
      drive_flags(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      READ_DATA_ON_RX = $urandom;
      k = $urandom_range(0, 10);
      w = 1'($urandom_range(0, 1));
      rel = $urandom_range(0, 20);
      do_xfer("rand", w, addrs[k], $urandom, rel);
      repeat (2) @(posedge PCLK);
      #1;
      chk("rand_irq", 32'(IRQ), 32'(|(m_istat & m_ien)));
      chk("rand_config_pin", 32'(I2C_CONFIG), 32'(m_cfg));
    end

    // Reset asserted while an RX read is stalled
    do_xfer("pre_rst_cfg", 1'b1, 8'h08, 32'h0000_0123, -1);
    do_xfer("pre_rst_ien", 1'b1, 8'h14, 32'hF, -1);
    drive_flags(TX_FULL, TX_EMPTY, 1'b1, ERROR);
    READ_DATA_ON_RX = 32'h1234_5678;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h04;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (3) begin
      @(negedge PCLK); chk("mid_wait_pready", 32'(PREADY), 32'd0);
    end
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_mid_pready", 32'(PREADY), 32'd0);
    chk("rst_mid_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_mid_prdata", PRDATA, 32'h0);
    chk("rst_mid_irq", 32'(IRQ), 32'd0);
    chk("rst_mid_config", 32'(I2C_CONFIG), 32'h0);
    drive_flags(TX_FULL, TX_EMPTY, 1'b0, ERROR);
    #1;
    chk("rst_mid_rd_ena", 32'(RD_ENA), 32'd0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    PRESETn = 1'b1;
    model_reset();
    do_xfer("post_rst_config", 1'b0, 8'h08, 32'h0, -1);
    do_xfer("post_rst_int_stat", 1'b0, 8'h18, 32'h0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
